// File: rtl/tmds_dc_balance_if.sv
// Symbol-stream bundle between the TMDS DC-balance stage and its neighbours.
// The master drives the transition-minimized word and control code; the slave returns the encoded symbol.
interface tmds_dc_balance_if;
    logic [8:0] q_m_in;
    logic       ve_in;
    logic [1:0] ctrl_in;
    logic [9:0] tmds_out;
    logic [4:0] tally_out;

    modport master (
        output q_m_in,
        output ve_in,
        output ctrl_in,
        input  tmds_out,
        input  tally_out
    );

    modport slave (
        input  q_m_in,
        input  ve_in,
        input  ctrl_in,
        output tmds_out,
        output tally_out
    );
endinterface

// File: rtl/tmds_dc_balance.sv
// TMDS stage 2: chooses per word whether to invert the data byte to keep the line DC balanced.
// Emits fixed control tokens during blanking, which also clears the running disparity.
module tmds_dc_balance (
    input logic              clk_in,
    input logic              rst_n_in,
    tmds_dc_balance_if.slave bus
);
    logic        [3:0] n1;
    logic signed [5:0] cnt;
    logic signed [5:0] n1_s;
    logic signed [5:0] n0_s;
    logic signed [5:0] diff;
    logic signed [5:0] cnt_next;
    logic signed [4:0] tally;
    logic        [9:0] sym;
    logic        [9:0] sym_next;
    logic              q8;
    logic        [7:0] data;

    always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, bus.q_m_in[i]};
        end
    end

    // Widen to 6 bits so intermediate sums like +8+2 cannot wrap.
    assign cnt  = {tally[4], tally};
    assign n1_s = $signed({2'b00, n1});
    assign n0_s = 6'sd8 - n1_s;
    assign diff = n1_s - n0_s;
    assign q8   = bus.q_m_in[8];
    assign data = bus.q_m_in[7:0];

    always_comb begin
        sym_next = 10'd0;
        cnt_next = 6'sd0;
        if (!bus.ve_in) begin
            unique case (bus.ctrl_in)
                2'b00: sym_next = 10'b1101010100;
                2'b01: sym_next = 10'b0010101011;
                2'b10: sym_next = 10'b0101010100;
                2'b11: sym_next = 10'b1010101011;
            endcase
        end else if ((cnt == 6'sd0) || (n1 == 4'd4)) begin
            sym_next = {~q8, q8, q8 ? data : ~data};
            cnt_next = q8 ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (n1 > 4'd4)) || ((cnt < 6'sd0) && (n1 < 4'd4))) begin
            sym_next = {1'b1, q8, ~data};
            cnt_next = cnt + (q8 ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym_next = {1'b0, q8, data};
            cnt_next = cnt + diff - (q8 ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sym   <= 10'd0;
            tally <= 5'sd0;
        end else begin
            sym   <= sym_next;
            tally <= cnt_next[4:0];
        end
    end

    assign bus.tmds_out  = sym;
    assign bus.tally_out = tally;
endmodule

// File: tb/tb_tmds_dc_balance.sv
// Directed and randomized checks of the TMDS DC-balance stage against hand values and a reference model.
module tb_tmds_dc_balance;
    logic clk_in;
    logic rst_n_in;
    int   n_checks;
    int   n_errors;
    int   ref_cnt;

    tmds_dc_balance_if bus ();

    tmds_dc_balance dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reference encoder written straight from the DVI balancing rules using plain integers.
    function automatic logic [9:0] ref_sym(input logic [8:0] q, input logic ve, input logic [1:0] c,
                                           input int cnt_in, output int cnt_out);
        int ones;
        int zeros;
        logic [9:0] s;
        ones = 0;
        for (int i = 0; i < 8; i++) if (q[i]) ones++;
        zeros = 8 - ones;
        if (!ve) begin
            cnt_out = 0;
            case (c)
                2'd0:    s = 10'b1101010100;
                2'd1:    s = 10'b0010101011;
                2'd2:    s = 10'b0101010100;
                default: s = 10'b1010101011;
            endcase
        end else if (cnt_in == 0 || ones == zeros) begin
            if (q[8]) begin
                s = {2'b01, q[7:0]};
                cnt_out = cnt_in + ones - zeros;
            end else begin
                s = {2'b10, ~q[7:0]};
                cnt_out = cnt_in + zeros - ones;
            end
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            s = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + (q[8] ? 2 : 0) + zeros - ones;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in + ones - zeros - (q[8] ? 0 : 2);
        end
        return s;
    endfunction

    initial begin
        logic [9:0] tokens [4];
        logic [9:0] exp_sym;
        int         next_cnt;
        int         t;

        tokens[0] = 10'b1101010100;
        tokens[1] = 10'b0010101011;
        tokens[2] = 10'b0101010100;
        tokens[3] = 10'b1010101011;
        n_checks = 0;
        n_errors = 0;

        rst_n_in       = 1'b0;
        bus.ve_in      = 1'b0;
        bus.ctrl_in    = 2'b00;
        bus.q_m_in     = 9'd0;
        #3;
        check("rst_tmds",  {6'd0, bus.tmds_out},  16'h0000);
        check("rst_tally", {11'd0, bus.tally_out}, 16'h0000);
        step();
        #2 rst_n_in = 1'b1;
        step();
        check("tok_first", {6'd0, bus.tmds_out}, {6'd0, tokens[0]});

        for (int i = 0; i < 4; i++) begin
            bus.ctrl_in = 2'(i);
            step();
            check("tok_sym",   {6'd0, bus.tmds_out},  {6'd0, tokens[i]});
            check("tok_tally", {11'd0, bus.tally_out}, 16'h0000);
        end

        bus.ve_in  = 1'b1;
        bus.q_m_in = 9'b1_0000_0000;
        step();
        check("w1_sym",   {6'd0, bus.tmds_out},  {6'd0, 10'b0100000000});
        check("w1_tally", {11'd0, bus.tally_out}, {11'd0, 5'b11000});
        step();
        check("w2_sym",   {6'd0, bus.tmds_out},  {6'd0, 10'b1111111111});
        check("w2_tally", {11'd0, bus.tally_out}, {11'd0, 5'b00010});
        bus.q_m_in = 9'b0_0000_1111;
        step();
        check("w3_sym",   {6'd0, bus.tmds_out},  {6'd0, 10'b1011110000});
        check("w3_tally", {11'd0, bus.tally_out}, {11'd0, 5'b00010});

        bus.ve_in   = 1'b0;
        bus.ctrl_in = 2'b00;
        step();
        check("blank_sym",   {6'd0, bus.tmds_out},  {6'd0, tokens[0]});
        check("blank_tally", {11'd0, bus.tally_out}, 16'h0000);
        bus.ve_in  = 1'b1;
        bus.q_m_in = 9'b1_1111_1111;
        step();
        check("post_blank_sym",   {6'd0, bus.tmds_out},  {6'd0, 10'b0111111111});
        check("post_blank_tally", {11'd0, bus.tally_out}, {11'd0, 5'b01000});

        // Tally is +8 here; a stale tally would turn the next all-ones word into Case B.
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_tmds",  {6'd0, bus.tmds_out},  16'h0000);
        check("arst_tally", {11'd0, bus.tally_out}, 16'h0000);
        step();
        #2 rst_n_in = 1'b1;
        bus.q_m_in = 9'b1_1111_1111;
        step();
        check("post_rst_sym",   {6'd0, bus.tmds_out},  {6'd0, 10'b0111111111});
        check("post_rst_tally", {11'd0, bus.tally_out}, {11'd0, 5'b01000});

        ref_cnt = 8;
        for (int k = 0; k < 10000; k++) begin
            bus.ve_in   = ($urandom_range(0, 7) != 0);
            bus.ctrl_in = 2'($urandom_range(0, 3));
            bus.q_m_in  = 9'($urandom_range(0, 511));
            exp_sym = ref_sym(bus.q_m_in, bus.ve_in, bus.ctrl_in, ref_cnt, next_cnt);
            ref_cnt = next_cnt;
            step();
            check("rnd_sym",   {6'd0, bus.tmds_out},  {6'd0, exp_sym});
            t = ref_cnt;
            check("rnd_tally", {11'd0, bus.tally_out}, {11'd0, t[4:0]});
            t = int'($signed(bus.tally_out));
            check("rnd_range", {15'd0, (t >= -8 && t <= 8)}, 16'h0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tmds_dc_balance.md
# tmds_dc_balance

TMDS stage 2 (DC balancing). Consumes the 9-bit transition-minimized word from the upstream `tm_choice` stage, or a 2-bit control code during blanking. Produces the 10-bit TMDS symbol for the serializer. It keeps a signed running disparity tally across pixels and decides, word by word, whether to invert the data byte so the serial line stays DC balanced.

## Interface

Parameters: none.

- `clk_in`, input, 1, pixel clock; all state updates on the rising edge.
- `rst_n_in`, input, 1, reset; **asynchronous, active-low**. Assert asynchronously, release synchronous to `clk_in`.
- `q_m_in`, input, 9, transition-minimized word. Bits [7:0] are data; bit [8] is the XOR/XNOR flag, 1 = XOR used.
- `ve_in`, input, 1, video enable. 1 = encode `q_m_in`; 0 = emit a control token.
- `ctrl_in`, input, 2, control code {C1,C0}, used only when `ve_in`=0.
- `tmds_out`, output, 10, registered TMDS symbol.
- `tally_out`, output, 5, signed two's-complement running disparity after the current symbol; debug/verification visibility.

## Operation

Per-cycle definitions:
- N1 = popcount(`q_m_in[7:0]`), 4-bit unsigned, range 0..8. N0 = 8 − N1.
- All tally arithmetic is signed and at least 6 bits internally; the stored `tally` is 5-bit signed.
- The DVI algorithm keeps the tally within ±8, so no overflow handling is required.

When `ve_in`=1, with `cnt` = current tally:
- Case A, `cnt`==0 or N1==N0:
  - `tmds_out` = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]}.
  - If q[8]=1: `cnt` += N1−N0. Otherwise: `cnt` += N0−N1.
- Case B, (`cnt`>0 and N1>N0) or (`cnt`<0 and N0>N1):
  - `tmds_out` = {1, q[8], ~q[7:0]}.
  - `cnt` += 2·q[8] + N0 − N1.
- Case C, otherwise:
  - `tmds_out` = {0, q[8], q[7:0]}.
  - `cnt` += N1 − N0 − 2·(~q[8]).
- Case A takes priority over B, and B over C.

When `ve_in`=0, `cnt` ← 0 and `tmds_out` takes a fixed token:
- `ctrl_in`=00 → 10'b1101010100
- `ctrl_in`=01 → 10'b0010101011
- `ctrl_in`=10 → 10'b0101010100
- `ctrl_in`=11 → 10'b1010101011

Other rules:
- `q_m_in` is ignored while `ve_in`=0.
- `ctrl_in` is ignored while `ve_in`=1.
- There is no handshake. One symbol is accepted and one produced every cycle; the block never stalls.

## Timing

- Latency is 1 cycle. Inputs sampled at edge k appear on `tmds_out`/`tally_out` after edge k.
- The Case A/B/C decision at edge k uses the tally registered at edge k−1. The tally is never a combinational function of the same-cycle output.
- Reset values, while `rst_n_in`=0 and immediately on assertion with no clock needed: `tmds_out`=10'b0000000000, `tally_out`=0.
- Reset mid-stream: the tally clears at once. The first symbol after release is computed from `cnt`=0, so it is always Case A.
- `ve_in` 1→0: the token appears after the next edge and the tally is 0 after that same edge.
- `ve_in` 0→1: the first data word is computed with `cnt`=0.
- Only `tmds_out` and `tally_out` are registered. The popcount and case selection are combinational, and the path must close at the pixel clock rate.

## Test plan

- **Reset and token:** hold `rst_n_in`=0 → `tmds_out`=0, `tally_out`=0. Release with `ve_in`=0, `ctrl_in`=00 → next edge gives 10'b1101010100.
- **All four tokens:** `ve_in`=0, sweep `ctrl_in` 00/01/10/11 → 1101010100, 0010101011, 0101010100, 1010101011 each one cycle later; `tally_out`=0 throughout.
- **Two-word sequence from `cnt`=0:**
  - `q_m_in`=9'b1_0000_0000 → `tmds_out`=10'b0100000000, tally −8.
  - Same word again → 10'b1111111111, tally +2.
  - `q_m_in`=9'b0_0000_1111 → 10'b1011110000, tally stays +2.
- **Blanking clears tally:** from tally +2, drive `ve_in`=0 for one cycle, then `q_m_in`=9'b1_1111_1111 → Case A: 10'b0111111111, tally +8.
- **Async reset mid-stream:** with tally ≠ 0, pulse `rst_n_in` low between edges → outputs go to 0 before the next edge. The first post-release word is encoded as Case A.
- **Random 10k words:** random `q_m_in`/`ve_in` → output bit-exact against a reference model; tally stays in −8..+8.
